// File: rtl/pbkdf2_multi.sv
// PBKDF2 controller around an external HMAC-SHA3-256 core.
// Derives NBLK 256-bit blocks. Each block is the XOR of c chained HMAC results.
// HMAC handshake: o_hmac_start pulses for one cycle. The key, message and length
// outputs stay stable until the core answers with i_hmac_done. i_hmac_mac is
// valid only in that cycle, and it is consumed only while the FSM is in WAIT.
module pbkdf2_multi #(
  parameter int NBLK  = 1,   // derived-key blocks, 1..8
  parameter int CNT_W = 16   // iteration-count width, 1..32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [1087:0]         i_pw,
  input  logic [1055:0]         i_salt,
  input  logic [CNT_W-1:0]      i_iter,
  output logic [256*NBLK-1:0]   o_key,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_hmac_start,
  output logic [1087:0]         o_hmac_key,
  output logic [1087:0]         o_hmac_msg,
  output logic [7:0]            o_hmac_len,
  input  logic                  i_hmac_done,
  input  logic [255:0]          i_hmac_mac
);

  // The block index must be able to hold NBLK itself (up to 8).
  localparam int BW = 4;
  localparam logic [BW-1:0] NBLK_B = BW'(NBLK);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic [1087:0]        pw_q, pw_d;
  logic [1055:0]        salt_q, salt_d;
  logic [CNT_W-1:0]     iter_q, iter_d;
  logic [BW-1:0]        b_q, b_d;
  logic [CNT_W-1:0]     j_q, j_d;
  logic [255:0]         u_q, u_d;
  logic [255:0]         t_q, t_d;
  logic [256*NBLK-1:0]  key_q, key_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 hmac_start_q, hmac_start_d;

  logic [CNT_W:0]       jp1;
  logic [BW-1:0]        bp1;
  logic [255:0]         t_new;

  // Next-state and datapath update for the whole controller.
  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    salt_d   = salt_q;
    iter_d   = iter_q;
    b_d      = b_q;
    j_d      = j_q;
    u_d      = u_q;
    t_d      = t_q;
    key_d    = key_q;
    ready_d  = ready_q;
    err_d    = err_q;
    // j is widened by one bit so that j+1 == 2^CNT_W-1 compares without wrapping.
    jp1      = {1'b0, j_q} + {{CNT_W{1'b0}}, 1'b1};
    bp1      = b_q + {{(BW-1){1'b0}}, 1'b1};
    t_new    = (j_q == '0) ? u_q : (t_q ^ u_q);

    if (i_abort) begin
      state_d = IDLE;
      key_d   = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            pw_d    = i_pw;
            salt_d  = i_salt;
            iter_d  = i_iter;
            key_d   = '0;
            ready_d = 1'b0;
            err_d   = 1'b0;
            b_d     = '0;
            j_d     = '0;
            u_d     = '0;
            t_d     = '0;
            if (i_iter == '0) begin
              state_d = DONE;
              err_d   = 1'b1;
              ready_d = 1'b1;
            end else begin
              state_d = ISSUE;
            end
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (i_hmac_done) begin
            u_d     = i_hmac_mac;
            state_d = ACC;
          end
        end
        ACC: begin
          t_d = t_new;
          j_d = jp1[CNT_W-1:0];
          if (jp1 == {1'b0, iter_q}) begin
            for (int k = 0; k < NBLK; k++) begin
              if (b_q == BW'(k)) key_d[(NBLK-1-k)*256 +: 256] = t_new;
            end
            b_d = bp1;
            if (bp1 == NBLK_B) begin
              state_d = DONE;
              ready_d = 1'b1;
            end else begin
              j_d     = '0;
              state_d = ISSUE;
            end
          end else begin
            state_d = ISSUE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d       = (state_d == ISSUE) || (state_d == WAIT) || (state_d == ACC);
    hmac_start_d = (state_d == ISSUE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pw_q         <= '0;
      salt_q       <= '0;
      iter_q       <= '0;
      b_q          <= '0;
      j_q          <= '0;
      u_q          <= '0;
      t_q          <= '0;
      key_q        <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      hmac_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_q         <= pw_d;
      salt_q       <= salt_d;
      iter_q       <= iter_d;
      b_q          <= b_d;
      j_q          <= j_d;
      u_q          <= u_d;
      t_q          <= t_d;
      key_q        <= key_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      hmac_start_q <= hmac_start_d;
    end
  end

  assign o_key        = key_q;
  assign o_ready      = ready_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;
  // An abort in the ISSUE cycle keeps the request from reaching the core.
  assign o_hmac_start = hmac_start_q & ~i_abort;
  assign o_hmac_key   = pw_q;
  // The first iteration hashes salt || INT(b+1). Later iterations hash the previous U.
  assign o_hmac_msg   = (j_q == '0) ? {salt_q, ({{(32-BW){1'b0}}, b_q} + 32'd1)}
                                    : {u_q, 832'b0};
  assign o_hmac_len   = (j_q == '0) ? 8'd136 : 8'd32;

endmodule

// File: tb/tb_pbkdf2_multi.sv
// Bench for pbkdf2_multi: one NBLK=1 and one NBLK=2 instance share the stimulus.
// Each instance has its own HMAC stub. The stub's MAC is a keyed mixing function,
// and the reference model evaluates PBKDF2 directly with that same function.
module tb_pbkdf2_multi;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  i_start;
  logic                  i_abort;
  logic [1087:0]         i_pw;
  logic [1055:0]         i_salt;
  logic [CNT_W-1:0]      i_iter;
  logic [255:0]          key0;
  logic [511:0]          key1;
  logic [1:0]            ready, busy, err, hs;
  logic [1:0]            hdone = '0;
  logic [1:0][255:0]     hmac = '0;
  logic [1:0][1087:0]    hkey, hmsg;
  logic [1:0][7:0]       hlen;

  pbkdf2_multi #(.NBLK(1), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_pw(i_pw), .i_salt(i_salt), .i_iter(i_iter), .o_key(key0),
    .o_ready(ready[0]), .o_busy(busy[0]), .o_err(err[0]),
    .o_hmac_start(hs[0]), .o_hmac_key(hkey[0]), .o_hmac_msg(hmsg[0]),
    .o_hmac_len(hlen[0]), .i_hmac_done(hdone[0]), .i_hmac_mac(hmac[0]));

  pbkdf2_multi #(.NBLK(2), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_pw(i_pw), .i_salt(i_salt), .i_iter(i_iter), .o_key(key1),
    .o_ready(ready[1]), .o_busy(busy[1]), .o_err(err[1]),
    .o_hmac_start(hs[1]), .o_hmac_key(hkey[1]), .o_hmac_msg(hmsg[1]),
    .o_hmac_len(hlen[1]), .i_hmac_done(hdone[1]), .i_hmac_mac(hmac[1]));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            d;
    logic [1087:0] msg;
    logic [7:0]    len;
    logic [1087:0] key;
    logic [255:0]  mac;
  } req_t;
  req_t log_q[$];

  // Stand-in PRF: chained rotate/xor/add over the message and key words.
  function automatic logic [255:0] prf(input logic [1087:0] k, input logic [1087:0] m,
                                       input logic [7:0] len);
    logic [255:0] a;
    a = 256'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1;
    for (int i = 0; i < 17; i++) begin
      a = {a[246:0], a[255:247]} ^ {4{m[i*64 +: 64]}};
      a = a + {4{k[i*64 +: 64] ^ 64'h9e3779b97f4a7c15}};
    end
    return a ^ {32{len}};
  endfunction

  // Reference PBKDF2 with the stand-in PRF; block 1 lands in the top 256 bits.
  function automatic logic [511:0] model(input int nblk, input logic [1087:0] pw,
                                         input logic [1055:0] salt, input int c);
    logic [511:0] res;
    logic [255:0] u, t;
    res = '0;
    for (int blk = 1; blk <= nblk; blk++) begin
      u = prf(pw, {salt, 32'(blk)}, 8'd136);
      t = u;
      for (int i = 2; i <= c; i++) begin
        u = prf(pw, {u, 832'b0}, 8'd32);
        t = t ^ u;
      end
      res = {res[255:0], t};
    end
    return res;
  endfunction

  // HMAC stubs. A latency of lat_cfg cycles, or a random 1..4 cycles when lat_cfg is 0.
  int           lat_cfg = 5;
  logic [1:0]   pend = '0;
  int           cnt[2];
  logic [255:0] mac_pend[2];
  logic [255:0] s_mac;
  int           s_lat;
  req_t         s_req;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      hdone[d] <= 1'b0;
      if (pend[d]) begin
        if (cnt[d] == 1) begin
          hdone[d] <= 1'b1;
          hmac[d]  <= mac_pend[d];
          pend[d]  <= 1'b0;
        end else begin
          cnt[d] <= cnt[d] - 1;
        end
      end
      if (hs[d]) begin
        s_mac     = prf(hkey[d], hmsg[d], hlen[d]);
        s_lat     = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
        s_req.d   = d;
        s_req.msg = hmsg[d];
        s_req.len = hlen[d];
        s_req.key = hkey[d];
        s_req.mac = s_mac;
        log_q.push_back(s_req);
        if (s_lat == 1) begin
          hdone[d] <= 1'b1;
          hmac[d]  <= s_mac;
        end else begin
          pend[d]     <= 1'b1;
          cnt[d]      <= s_lat - 1;
          mac_pend[d] <= s_mac;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int count_req(input int d, input int base);
    int n = 0;
    foreach (log_q[i]) if (i >= base && log_q[i].d == d) n++;
    return n;
  endfunction

  function automatic req_t nth_req(input int d, input int n, input int base);
    int   k = 0;
    req_t r;
    r.d = -1; r.msg = '0; r.len = '0; r.key = '0; r.mac = '0;
    foreach (log_q[i]) begin
      if (i >= base && log_q[i].d == d) begin
        if (k == n) return log_q[i];
        k++;
      end
    end
    return r;
  endfunction

  task automatic new_data();
    for (int i = 0; i < 34; i++) i_pw[i*32 +: 32] = $urandom;
    for (int i = 0; i < 33; i++) i_salt[i*32 +: 32] = $urandom;
  endtask

  // Called at a negedge. Holds start for `hold` cycles and optionally re-asserts
  // it for two cycles from cycle re_at. Returns the cycle count to each ready.
  task automatic start_and_wait(input int hold, input int re_at, input int budget,
                                output int n0, output int n1);
    n0 = -1;
    n1 = -1;
    i_start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == hold) i_start = 1'b0;
      if (re_at > 0 && c == re_at) i_start = 1'b1;
      if (re_at > 0 && c == re_at + 2) i_start = 1'b0;
      if (ready[0] && n0 < 0) n0 = c;
      if (ready[1] && n1 < 0) n1 = c;
      if (n0 >= 0 && n1 >= 0 && c > hold) break;
    end
    i_start = 1'b0;
    chk("ready_within_budget", {30'b0, n0 >= 0, n1 >= 0}, 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   n0, n1, base;
    req_t r, r1, r2;
    logic [255:0] a, b, c, d;

    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_iter = '0;
    i_pw = '0; i_salt = '0;
    repeat (3) @(negedge clk);
    chk("rst_key0", key0, '0);
    chk("rst_key1", key1, '0);
    chk("rst_ready", ready, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_hstart", hs, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // c=1, L=5: one request per block, 8 and 15 cycles to ready.
    new_data(); i_iter = 1; lat_cfg = 5; base = log_q.size();
    start_and_wait(1, 0, 100, n0, n1);
    chk("c1_latency_n1", n0, 8);
    chk("c1_latency_n2", n1, 15);
    chk("c1_key_n1", key0, model(1, i_pw, i_salt, 1));
    chk("c1_key_n2", key1, model(2, i_pw, i_salt, 1));
    r = nth_req(0, 0, base);
    chk("c1_int", r.msg[31:0], 32'h1);
    chk("c1_len", r.len, 8'd136);
    chk("c1_salt", r.msg[1087:32], i_salt);
    chk("c1_hkey", r.key, i_pw);
    chk("c1_busy_done", busy, 2'b00);

    // c=3, random latency: chained U values and the XOR accumulation.
    new_data(); i_iter = 3; lat_cfg = 0; base = log_q.size();
    start_and_wait(1, 0, 200, n0, n1);
    chk("c3_key_n1", key0, model(1, i_pw, i_salt, 3));
    chk("c3_key_n2", key1, model(2, i_pw, i_salt, 3));
    chk("c3_nreq_n1", count_req(0, base), 3);
    for (int i = 1; i < 3; i++) begin
      r1 = nth_req(0, i - 1, base);
      r2 = nth_req(0, i, base);
      chk("c3_chain_msg", r2.msg[1087:832], r1.mac);
      chk("c3_chain_pad", r2.msg[831:0], '0);
      chk("c3_chain_len", r2.len, 8'd32);
    end
    a = nth_req(0, 0, base).mac; b = nth_req(0, 1, base).mac; c = nth_req(0, 2, base).mac;
    chk("c3_xor", key0, a ^ b ^ c);

    // NBLK=2, c=2: block order and the second block index.
    new_data(); i_iter = 2; lat_cfg = 0; base = log_q.size();
    start_and_wait(1, 0, 200, n0, n1);
    a = nth_req(1, 0, base).mac; b = nth_req(1, 1, base).mac;
    c = nth_req(1, 2, base).mac; d = nth_req(1, 3, base).mac;
    chk("c2_blk1", key1[511:256], a ^ b);
    chk("c2_blk2", key1[255:0], c ^ d);
    chk("c2_int2", nth_req(1, 2, base).msg[31:0], 32'h2);
    chk("c2_key_model", key1, model(2, i_pw, i_salt, 2));

    // c=0 is rejected at once, with no HMAC traffic.
    i_iter = 0; base = log_q.size();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("c0_err", err, 2'b11);
    chk("c0_ready", ready, 2'b11);
    chk("c0_busy", busy, 2'b00);
    chk("c0_key0", key0, '0);
    chk("c0_key1", key1, '0);
    repeat (8) @(negedge clk);
    chk("c0_no_req", log_q.size(), base);

    // Abort in WAIT; the stub's late done must be ignored.
    new_data(); i_iter = 2; lat_cfg = 5;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ab_busy_pre", busy, 2'b11);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("ab_busy", busy, 2'b00);
    chk("ab_ready", ready, 2'b00);
    chk("ab_err", err, 2'b00);
    chk("ab_key", {key1[255:0], key0}, '0);
    repeat (10) @(negedge clk);
    chk("ab_late_busy", busy, 2'b00);
    chk("ab_late_ready", ready, 2'b00);
    chk("ab_late_key", {key1[255:0], key0}, '0);
    new_data(); i_iter = 1;
    start_and_wait(1, 0, 100, n0, n1);
    chk("ab_rerun_n1", key0, model(1, i_pw, i_salt, 1));
    chk("ab_rerun_n2", key1, model(2, i_pw, i_salt, 1));

    // Reset in WAIT; again the late done must be ignored.
    new_data(); i_iter = 2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_async_busy", busy, 2'b00);
    chk("rs_async_hstart", hs, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rs_late_busy", busy, 2'b00);
    chk("rs_late_ready", ready, 2'b00);
    chk("rs_late_key", key1, '0);
    new_data(); i_iter = 2; lat_cfg = 0;
    start_and_wait(1, 0, 200, n0, n1);
    chk("rs_rerun_n1", key0, model(1, i_pw, i_salt, 2));
    chk("rs_rerun_n2", key1, model(2, i_pw, i_salt, 2));

    // Start held two cycles and re-asserted mid-run: exactly one run per DUT.
    new_data(); i_iter = 2; lat_cfg = 4; base = log_q.size();
    start_and_wait(2, 5, 200, n0, n1);
    repeat (3) @(negedge clk);
    chk("hold_nreq_n1", count_req(0, base), 2);
    chk("hold_nreq_n2", count_req(1, base), 4);
    chk("hold_key_n2", key1, model(2, i_pw, i_salt, 2));

    // Random runs.
    lat_cfg = 0;
    for (int t = 0; t < 5; t++) begin
      new_data(); i_iter = CNT_W'($urandom_range(1, 4));
      start_and_wait(1, 0, 400, n0, n1);
      chk("rnd_key_n1", key0, model(1, i_pw, i_salt, int'(i_iter)));
      chk("rnd_key_n2", key1, model(2, i_pw, i_salt, int'(i_iter)));
      chk("rnd_err", err, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pbkdf2_multi.md
PBKDF2_MULTI -- requirements
Module: pbkdf2_multi

Interface
REQ-001 SHALL have parameter NBLK, default 1, giving the number of 256-bit derived-key blocks (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, giving the iteration-count width (legal 1..32).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  run request; level, sampled each cycle.
REQ-006 SHALL have port i_abort  input  1  cancel the current run.
REQ-007 SHALL have port i_pw  input  1088  password, used as the HMAC key.
REQ-008 SHALL have port i_salt  input  1056  salt, exactly 132 bytes.
REQ-009 SHALL have port i_iter  input  CNT_W  iteration count c.
REQ-010 SHALL have port o_key  output  256*NBLK  derived key; block 1 occupies the most-significant 256 bits.
REQ-011 SHALL have port o_ready  output  1  result valid, held high.
REQ-012 SHALL have port o_busy  output  1  run in progress.
REQ-013 SHALL have port o_err  output  1  run rejected because c == 0.
REQ-014 SHALL have port o_hmac_start  output  1  one-cycle request to the external HMAC-SHA3-256 core.
REQ-015 SHALL have ports o_hmac_key (1088), o_hmac_msg (1088) and o_hmac_len (8, message length in bytes), all outputs, all stable from o_hmac_start until i_hmac_done.
REQ-016 SHALL have ports i_hmac_done (input, 1) and i_hmac_mac (input, 256); the MAC is valid in the cycle i_hmac_done is high.

Function
REQ-017 SHALL use states IDLE, ISSUE, WAIT, ACC, DONE.
REQ-018 SHALL, in IDLE or DONE with i_start=1, capture i_pw, i_salt and i_iter, clear o_ready/o_err/o_key, zero the block index b and the iteration counter j, and move to ISSUE next cycle; if i_iter == 0 it SHALL instead move to DONE with o_err=1.
REQ-019 SHALL ignore i_start in ISSUE, WAIT and ACC; a start held for 2 cycles SHALL begin exactly one run.
REQ-020 SHALL, in ISSUE, pulse o_hmac_start for exactly one cycle, then enter WAIT.
REQ-021 SHALL, when j == 0, drive o_hmac_msg = {salt, INT(b+1)} with o_hmac_len = 136, where INT is a 32-bit big-endian index.
REQ-022 SHALL, when j > 0, drive o_hmac_msg = {U_prev, 832'b0} with o_hmac_len = 32.
REQ-023 SHALL remain in WAIT until i_hmac_done=1, then register i_hmac_mac as U_prev and enter ACC.
REQ-024 SHALL, in ACC, set T = U (when j == 0) or T ^= U (when j > 0), then increment j.
REQ-025 SHALL, in ACC when j+1 == c, write T into o_key block b+1 and increment b; if b+1 == NBLK it SHALL enter DONE, otherwise it SHALL reset j to 0 and enter ISSUE.
REQ-026 SHALL, in ACC when j+1 < c, enter ISSUE.
REQ-027 SHALL, in DONE, hold o_ready=1 and o_key stable until the next accepted start, abort or reset.
REQ-028 SHALL drive o_busy=1 exactly in ISSUE, WAIT and ACC.
REQ-029 SHALL make each iteration cost 2 + L cycles, where L is the HMAC latency in cycles (ISSUE to done, done ≥ 1 cycle after start); total run time SHALL be NBLK·c·(2+L)+1 cycles from start to o_ready.
REQ-030 SHALL, on i_abort=1 in any state, go to IDLE next cycle, zero o_key/o_ready/o_err, and suppress any o_hmac_start in that cycle; an abort SHALL take priority over a simultaneous start.
REQ-031 SHALL ignore an i_hmac_done that arrives outside WAIT.
REQ-032 SHALL treat the maximum c (2^CNT_W−1) without counter wrap-around, with j sized CNT_W bits.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force IDLE, o_key=0, o_ready=0, o_busy=0, o_err=0, o_hmac_start=0, and zero the counters and T/U; reset mid-WAIT SHALL discard the pending HMAC result.

Verification
REQ-034 SHALL check: NBLK=1, c=1, stub HMAC with L=5 returning A -> o_key=A, o_ready rises 8 cycles after start, msg low 32 bits = 0x00000001, len=136.
REQ-035 SHALL check: c=3, stub returns A, B, C -> o_key=A^B^C; the 2nd and 3rd requests have msg[1087:832] = the prior MAC and len=32.
REQ-036 SHALL check: NBLK=2, c=2 -> block 1 = A^B in the top 256 bits, block 2 = C^D; the 3rd request carries INT=0x00000002.
REQ-037 SHALL check: c=0 -> o_err=1, o_ready=1, o_key=0, no o_hmac_start ever.
REQ-038 SHALL check: abort during WAIT, and separately rst_n low during WAIT -> IDLE, outputs zero, a late i_hmac_done is ignored, and the next start completes correctly.
REQ-039 SHALL check: i_start held for 2 cycles and re-asserted while busy -> exactly NBLK·c HMAC requests are issued.
